sonar_scheduler: RTL
====================

Name: sonar_scheduler

Overview:
Time-multiplexes up to N_SENSORS HC-SR04 ultrasonic rangers so only one fires per slot, which avoids acoustic crosstalk. For each enabled sensor in round-robin order it generates the trigger pulse, times the echo, and converts the echo width to a U(32,15) distance in cm. It sits between the sensor pins and the navigation logic, and presents a per-sensor distance bank plus a one-cycle update strobe.

Parameters:
N_SENSORS, 3, number of sensors served (1..8)
SENSOR_ID_WIDTH, 3, width of the sensor index output (ceil(log2(N_SENSORS)) or larger)
TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
SLOT_CYCLES, 1500000, total slot length per sensor in clocks (30 ms)
TIMEOUT_CYCLES, 1250000, maximum echo wait plus width, counted from trigger fall (25 ms); must be less than SLOT_CYCLES - TRIG_CYCLES
ECHO_INC, 11, U(32,15) distance added per clock while echo is high (~0.000343 cm per 20 ns)
N_WIDTH, 32, distance word width
Q_WIDTH, 15, fractional bits

Ports:
SONAR_SCHEDULER_CLOCK_50  in  1  system clock, 50 MHz
SONAR_SCHEDULER_RESET_InLow  in  1  asynchronous active-low reset
SONAR_SCHEDULER_ENABLE_InHigh  in  1  run/stop the scan
SONAR_SCHEDULER_MASK_InBus  in  N_SENSORS  per-sensor enable mask
SONAR_SCHEDULER_ECHO_InBus  in  N_SENSORS  raw echo inputs, asynchronous
SONAR_SCHEDULER_TRIGGER_OutBus  out  N_SENSORS  trigger outputs, at most one high
SONAR_SCHEDULER_DISTANCE_OutBus  out  N_SENSORS*N_WIDTH  distance bank; sensor i occupies bits [i*N_WIDTH +: N_WIDTH]
SONAR_SCHEDULER_VALID_Out  out  1  one-cycle pulse when a bank entry updates
SONAR_SCHEDULER_SENSOR_OutBus  out  SENSOR_ID_WIDTH  index of the updated entry, valid with VALID
SONAR_SCHEDULER_TIMEOUT_OutBus  out  N_SENSORS  per-sensor sticky flag: last measurement timed out

Behaviour:
- Clock and reset: one clock, SONAR_SCHEDULER_CLOCK_50. SONAR_SCHEDULER_RESET_InLow is asynchronous and active-low.
- Reset values: every output 0; state IDLE; current index 0; all counters 0; echo synchronisers 0.
- Echo inputs pass through 2-FF synchronisers. All echo logic uses the synchronised value, so there are 2 cycles of input latency.
- IDLE:
  - Leave when ENABLE=1 and MASK != 0.
  - Select the next set mask bit at or after the current index (round-robin, wrapping), then go to TRIGGER.
  - If MASK = 0, stay in IDLE with triggers low.
- TRIGGER:
  - TRIGGER_OutBus[sel] is high for exactly TRIG_CYCLES clocks; the slot counter starts at 0 on entry.
  - Clear the accumulator, then go to WAIT_ECHO.
- WAIT_ECHO:
  - Wait for a rising edge of the synchronised echo[sel]. An echo already high on entry is not a start; a low-to-high transition is required.
  - On the rising edge, go to MEASURE.
  - If the timeout counter reaches TIMEOUT_CYCLES, go to FAIL.
- MEASURE:
  - Add ECHO_INC to the accumulator each clock while echo is high. The addition is N_WIDTH wide and saturates at all-ones.
  - On echo falling, go to STORE.
  - If the timeout counter reaches TIMEOUT_CYCLES, go to FAIL.
- STORE (1 cycle):
  - bank[sel] <= accumulator; TIMEOUT[sel] <= 0.
  - VALID=1 and SENSOR=sel in this cycle; go to GUARD.
- FAIL (1 cycle):
  - bank[sel] <= all-ones; TIMEOUT[sel] <= 1.
  - VALID=1 and SENSOR=sel; go to GUARD.
- GUARD:
  - Idle until the slot counter reaches SLOT_CYCLES-1.
  - Then advance the index to sel+1 mod N_SENSORS and go to IDLE-select. When ENABLE=1 and MASK != 0, this is zero-cycle: the next TRIGGER starts on the following clock.
- Slot period: every slot is exactly SLOT_CYCLES clocks, from trigger rise to the next trigger rise, regardless of the measurement outcome.
- Mask and enable changes:
  - MASK is sampled only at selection; changing it mid-slot does not abort the slot.
  - Deasserting ENABLE mid-slot completes the current slot (including STORE/FAIL), then the block rests in IDLE.
- Bank retention: entries for masked-off sensors keep their last value.
- Echo on a non-selected sensor is ignored.
- Reset mid-operation: all outputs return to 0 immediately (asynchronous), including any trigger.

Decomposition:
- Shared package: state encoding (IDLE, TRIGGER, WAIT_ECHO, MEASURE, STORE, FAIL, GUARD), default timing constants, U(32,15) ECHO_INC and saturation constant.
- One natural sub-module, sonar_echo_timer: synchroniser, edge detect, accumulator, and timeout counter for the selected channel. It takes start/sel and returns done/timeout/distance.

Test Plan:
- Reset then ENABLE=1, MASK=3'b111, every echo a 1000-cycle pulse starting 200 cycles after trigger fall -> triggers fire in order 0,1,2,0, each 500 cycles wide, rises 1,500,000 cycles apart; VALID with SENSOR 0,1,2; each distance = 1000*11 = 11000 (0.3357 cm).
- MASK=3'b101, echo 0 of 5000 cycles -> sensor 1 never triggered; sequence 0,2,0; bank[0]=55000; bank[1] unchanged at 0.
- Echo 2 never rises -> after 1,250,000 cycles, FAIL: bank[2]=32'hFFFFFFFF, TIMEOUT[2]=1, VALID with SENSOR=2; a later good echo clears TIMEOUT[2].
- Echo held high before and through the trigger -> no measurement starts; timeout path taken, TIMEOUT=1.
- ENABLE dropped 100 cycles into MEASURE of sensor 1 -> measurement completes, VALID for sensor 1, GUARD runs to the slot end, then no further triggers.
- RESET_InLow pulsed low while a trigger is high -> trigger, VALID, bank and TIMEOUT all 0 within the same cycle; the scan restarts at sensor 0 after release.

Source files
------------

// File: rtl/sonar_scheduler_pkg.sv
// Shared types and default timing for the multiplexed HC-SR04 scheduler.
// Distances are U(32,15) centimetres.
package sonar_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_STORE,
        ST_FAIL,
        ST_GUARD
    } sonar_state_e;

    localparam int          SONAR_MAX_SENSORS    = 8;
    localparam int          SONAR_TRIG_CYCLES    = 500;
    localparam int          SONAR_SLOT_CYCLES    = 1500000;
    localparam int          SONAR_TIMEOUT_CYCLES = 1250000;
    localparam int          SONAR_ECHO_INC       = 11;
    localparam int          SONAR_N_WIDTH        = 32;
    localparam int          SONAR_Q_WIDTH        = 15;
    localparam logic [31:0] SONAR_DIST_SAT       = 32'hFFFF_FFFF;

    // First set mask bit at or after 'from', wrapping modulo n.
    function automatic logic [2:0] next_sensor(input logic [7:0] mask,
                                               input logic [2:0] from,
                                               input int         n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = from;
        found = 1'b0;
        for (int i = 0; i < SONAR_MAX_SENSORS; i++) begin
            idx = (int'(from) + i) % n;
            if (!found && (i < n) && mask[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sonar_scheduler_echo_timer.sv
// Echo synchronisers, edge detection, saturating distance accumulator and
// timeout counter for whichever sensor is currently selected.
module sonar_echo_timer
    import sonar_scheduler_pkg::*;
#(
    parameter int N_SENSORS      = 3,
    parameter int TIMEOUT_CYCLES = SONAR_TIMEOUT_CYCLES,
    parameter int ECHO_INC       = SONAR_ECHO_INC,
    parameter int N_WIDTH        = SONAR_N_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_SENSORS-1:0] echo_i,
    input  logic [2:0]           sel_i,
    input  logic                 start_i,
    output logic                 rise_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [N_WIDTH-1:0]   dist_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [N_SENSORS-1:0] sync1_q, sync2_q, sync3_q;
    logic                 active_q, meas_q;
    logic [TW-1:0]        tmo_cnt_q;
    logic [N_WIDTH-1:0]   acc_q;
    logic [7:0]           lvl_w, prev_w;
    logic                 echo_w, echo_prev_w;

    function automatic logic [N_WIDTH-1:0] sat_add(input logic [N_WIDTH-1:0] a);
        logic [N_WIDTH:0] sum;
        sum = {1'b0, a} + (N_WIDTH+1)'(ECHO_INC);
        return sum[N_WIDTH] ? {N_WIDTH{1'b1}} : sum[N_WIDTH-1:0];
    endfunction

    assign lvl_w       = 8'(sync2_q);
    assign prev_w      = 8'(sync3_q);
    assign echo_w      = lvl_w[sel_i];
    assign echo_prev_w = prev_w[sel_i];

    // A start needs a genuine low-to-high step; a level already high is ignored.
    assign rise_o    = active_q && !meas_q && echo_w && !echo_prev_w;
    assign done_o    = meas_q && !echo_w;
    assign timeout_o = active_q && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign dist_o    = acc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            active_q  <= 1'b0;
            meas_q    <= 1'b0;
            tmo_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            sync1_q <= echo_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (start_i) begin
                active_q  <= 1'b1;
                meas_q    <= 1'b0;
                tmo_cnt_q <= '0;
                acc_q     <= '0;
            end else if (active_q) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
                if (done_o || timeout_o) begin
                    active_q <= 1'b0;
                    meas_q   <= 1'b0;
                end else begin
                    if (rise_o) meas_q <= 1'b1;
                    if (echo_w && (meas_q || rise_o)) acc_q <= sat_add(acc_q);
                end
            end
        end
    end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin HC-SR04 scheduler: one sensor fires per fixed-length slot and
// its echo width is converted into a U(32,15) distance bank entry.
module sonar_scheduler
    import sonar_scheduler_pkg::*;
#(
    parameter int N_SENSORS       = 3,
    parameter int SENSOR_ID_WIDTH = 3,
    parameter int TRIG_CYCLES     = SONAR_TRIG_CYCLES,
    parameter int SLOT_CYCLES     = SONAR_SLOT_CYCLES,
    parameter int TIMEOUT_CYCLES  = SONAR_TIMEOUT_CYCLES,
    parameter int ECHO_INC        = SONAR_ECHO_INC,
    parameter int N_WIDTH         = SONAR_N_WIDTH,
    parameter int Q_WIDTH         = SONAR_Q_WIDTH
) (
    input  logic                           SONAR_SCHEDULER_CLOCK_50,
    input  logic                           SONAR_SCHEDULER_RESET_InLow,
    input  logic                           SONAR_SCHEDULER_ENABLE_InHigh,
    input  logic [N_SENSORS-1:0]           SONAR_SCHEDULER_MASK_InBus,
    input  logic [N_SENSORS-1:0]           SONAR_SCHEDULER_ECHO_InBus,
    output logic [N_SENSORS-1:0]           SONAR_SCHEDULER_TRIGGER_OutBus,
    output logic [N_SENSORS*N_WIDTH-1:0]   SONAR_SCHEDULER_DISTANCE_OutBus,
    output logic                           SONAR_SCHEDULER_VALID_Out,
    output logic [SENSOR_ID_WIDTH-1:0]     SONAR_SCHEDULER_SENSOR_OutBus,
    output logic [N_SENSORS-1:0]           SONAR_SCHEDULER_TIMEOUT_OutBus
);

    localparam int CW = $clog2(SLOT_CYCLES + 1);

    if (N_SENSORS < 1 || N_SENSORS > SONAR_MAX_SENSORS || Q_WIDTH >= N_WIDTH ||
        TIMEOUT_CYCLES >= SLOT_CYCLES - TRIG_CYCLES) begin : g_bad_params
        $error("sonar_scheduler: inconsistent parameter set");
    end

    sonar_state_e                 state_q;
    logic [2:0]                   sel_q;
    logic [CW-1:0]                slot_cnt_q;
    logic [N_SENSORS-1:0]         trig_q, tmo_q;
    logic [N_SENSORS*N_WIDTH-1:0] bank_q;
    logic                         valid_q;
    logic [SENSOR_ID_WIDTH-1:0]   sensor_q;

    logic               go_w, start_w, rise_w, done_w, timeout_w, fin_w, ok_w;
    logic [2:0]         wrap_w, from_w, pick_w;
    logic [N_WIDTH-1:0] dist_w;

    function automatic logic [N_SENSORS-1:0] sensor_bit(input logic [2:0] s);
        logic [N_SENSORS-1:0] b;
        b = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (3'(i) == s) b[i] = 1'b1;
        end
        return b;
    endfunction

    assign go_w    = SONAR_SCHEDULER_ENABLE_InHigh && (SONAR_SCHEDULER_MASK_InBus != '0);
    assign wrap_w  = 3'((int'(sel_q) + 1) % N_SENSORS);
    assign from_w  = (state_q == ST_GUARD) ? wrap_w : sel_q;
    assign pick_w  = next_sensor(8'(SONAR_SCHEDULER_MASK_InBus), from_w, N_SENSORS);
    assign start_w = (state_q == ST_TRIGGER) && (slot_cnt_q == CW'(TRIG_CYCLES - 1));

    // Measurement ends here; a completed echo takes priority over a coincident timeout.
    assign ok_w  = (state_q == ST_MEASURE) && done_w;
    assign fin_w = ok_w || (((state_q == ST_WAIT_ECHO) || (state_q == ST_MEASURE)) && timeout_w);

    sonar_echo_timer #(
        .N_SENSORS      (N_SENSORS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ECHO_INC       (ECHO_INC),
        .N_WIDTH        (N_WIDTH)
    ) u_timer (
        .clk_i     (SONAR_SCHEDULER_CLOCK_50),
        .rst_ni    (SONAR_SCHEDULER_RESET_InLow),
        .echo_i    (SONAR_SCHEDULER_ECHO_InBus),
        .sel_i     (sel_q),
        .start_i   (start_w),
        .rise_o    (rise_w),
        .done_o    (done_w),
        .timeout_o (timeout_w),
        .dist_o    (dist_w)
    );

    always_ff @(posedge SONAR_SCHEDULER_CLOCK_50 or negedge SONAR_SCHEDULER_RESET_InLow) begin
        if (!SONAR_SCHEDULER_RESET_InLow) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            slot_cnt_q <= '0;
            trig_q     <= '0;
            tmo_q      <= '0;
            bank_q     <= '0;
            valid_q    <= 1'b0;
            sensor_q   <= '0;
        end else begin
            valid_q    <= 1'b0;
            slot_cnt_q <= slot_cnt_q + CW'(1);
            if (fin_w) begin
                valid_q  <= 1'b1;
                sensor_q <= SENSOR_ID_WIDTH'(sel_q);
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (3'(i) == sel_q) begin
                        bank_q[i*N_WIDTH +: N_WIDTH] <= ok_w ? dist_w : {N_WIDTH{1'b1}};
                        tmo_q[i]                     <= !ok_w;
                    end
                end
            end
            case (state_q)
                ST_IDLE: begin
                    slot_cnt_q <= '0;
                    if (go_w) begin
                        sel_q   <= pick_w;
                        trig_q  <= sensor_bit(pick_w);
                        state_q <= ST_TRIGGER;
                    end
                end
                ST_TRIGGER: begin
                    if (start_w) begin
                        trig_q  <= '0;
                        state_q <= ST_WAIT_ECHO;
                    end
                end
                ST_WAIT_ECHO: begin
                    if (timeout_w)   state_q <= ST_FAIL;
                    else if (rise_w) state_q <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (done_w)         state_q <= ST_STORE;
                    else if (timeout_w) state_q <= ST_FAIL;
                end
                ST_STORE, ST_FAIL: state_q <= ST_GUARD;
                ST_GUARD: begin
                    // Back-to-back slots: the next trigger rises on the clock after the slot's last cycle.
                    if (slot_cnt_q >= CW'(SLOT_CYCLES - 1)) begin
                        slot_cnt_q <= '0;
                        if (go_w) begin
                            sel_q   <= pick_w;
                            trig_q  <= sensor_bit(pick_w);
                            state_q <= ST_TRIGGER;
                        end else begin
                            sel_q   <= wrap_w;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SONAR_SCHEDULER_TRIGGER_OutBus  = trig_q;
    assign SONAR_SCHEDULER_DISTANCE_OutBus = bank_q;
    assign SONAR_SCHEDULER_VALID_Out       = valid_q;
    assign SONAR_SCHEDULER_SENSOR_OutBus   = sensor_q;
    assign SONAR_SCHEDULER_TIMEOUT_OutBus  = tmo_q;

endmodule
